led_bcm_scheduler: RTL and testbench

LED_BCM_SCHEDULER -- requirements
Module: led_bcm_scheduler

---
 rtl/led_pkg.sv | 18 +
 rtl/led_on_timer.sv | 27 ++
 rtl/led_bcm_scheduler.sv | 150 +++++++++++++++
 tb/tb_led_bcm_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED panel BCM scheduler: one-hot state encoding,
// default geometry and the shift watchdog limit.
package led_pkg;

   localparam int         ROW_BITS_DEF = 5;
   localparam int         PLANES_DEF   = 8;
   localparam logic [7:0] WD_LIMIT     = 8'd255;

   typedef enum logic [5:0] {
      S_IDLE    = 6'b000001,
      S_SHIFT   = 6'b000010,
      S_HOLD    = 6'b000100,
      S_BLANK   = 6'b001000,
      S_LATCH   = 6'b010000,
      S_UNBLANK = 6'b100000
   } state_t;

endpackage

// File: rtl/led_on_timer.sv
// Display on-time countdown: loads a tick count and decrements to zero, saturating.
module led_on_timer #(
   parameter int TICK_BITS = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 load,
   input  logic [TICK_BITS-1:0] value,
   output logic                 zero
);

   logic [TICK_BITS-1:0] count_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= value;
      end else if (count_q != '0) begin
         count_q <= count_q - TICK_BITS'(1);
      end
   end

   // Flags the cycle in which the count runs out, so a loaded value of N gives N on-cycles.
   assign zero = (count_q <= TICK_BITS'(1));

endmodule

// File: rtl/led_bcm_scheduler.sv
// Row/bit-plane scheduler for a HUB75-style panel using binary-coded modulation.
// Optional shift watchdog and sticky shift_timeout output: define LED_SCHED_WATCHDOG_EN.
module led_bcm_scheduler
   import led_pkg::*;
#(
   parameter int ROW_BITS   = ROW_BITS_DEF,
   parameter int PLANES     = PLANES_DEF,
   parameter int BASE_TICKS = 4,
   parameter int TICK_BITS  = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       enable,
   output logic                       shift_start,
   output logic [ROW_BITS-1:0]        shift_row,
   output logic [$clog2(PLANES)-1:0]  shift_plane,
   input  logic                       shift_done,
   output logic [ROW_BITS-1:0]        led_addr,
   output logic                       led_latch,
   output logic                       led_blank,
   output logic                       frame_strobe,
   output logic                       busy,
`ifdef LED_SCHED_WATCHDOG_EN
   output logic                       shift_timeout,
`endif
   output state_t                     fsm_state
);

   localparam int PLANE_BITS = $clog2(PLANES);

   state_t                state_q, state_d;
   logic                  first_q;
   logic                  blank_q;
   logic [ROW_BITS-1:0]   addr_q;
   logic [ROW_BITS-1:0]   row_q;
   logic [PLANE_BITS-1:0] plane_q;
   logic [PLANE_BITS-1:0] lat_plane_q;
   logic                  timer_load;
   logic                  timer_zero;
   logic [TICK_BITS-1:0]  load_value;
   logic                  last_plane;
   logic                  last_row;

   assign last_plane = (plane_q == PLANE_BITS'(PLANES - 1));
   assign last_row   = &row_q;
   assign load_value = TICK_BITS'(BASE_TICKS) << lat_plane_q;

`ifdef LED_SCHED_WATCHDOG_EN
   logic [7:0] wd_q;
   logic       timeout_q;
   logic       wd_fire;

   assign wd_fire = (state_q == S_SHIFT) && !(!first_q && shift_done)
                    && (wd_q == WD_LIMIT - 8'd1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q != S_SHIFT) wd_q <= '0;
         else                    wd_q <= wd_q + 8'd1;
         if (wd_fire) timeout_q <= 1'b1;
      end
   end

   assign shift_timeout = timeout_q;
`endif

   always_comb begin
      state_d      = state_q;
      shift_start  = 1'b0;
      led_latch    = 1'b0;
      frame_strobe = 1'b0;
      timer_load   = 1'b0;
      case (state_q)
         S_IDLE:    if (enable) state_d = S_SHIFT;
         S_SHIFT: begin
            shift_start = first_q;
            // A done pulse in the same cycle as the start request is stale.
            if (!first_q && shift_done) state_d = S_HOLD;
`ifdef LED_SCHED_WATCHDOG_EN
            else if (wd_fire) state_d = S_IDLE;
`endif
         end
         S_HOLD:    if (timer_zero) state_d = enable ? S_BLANK : S_IDLE;
         S_BLANK:   state_d = S_LATCH;
         S_LATCH: begin
            led_latch = 1'b1;
            state_d   = S_UNBLANK;
         end
         S_UNBLANK: begin
            timer_load   = 1'b1;
            frame_strobe = last_plane && last_row;
            state_d      = S_SHIFT;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         first_q     <= 1'b0;
         blank_q     <= 1'b1;
         addr_q      <= '0;
         row_q       <= '0;
         plane_q     <= '0;
         lat_plane_q <= '0;
      end else begin
         state_q <= state_d;
         first_q <= (state_d == S_SHIFT) && (state_q != S_SHIFT);
         if (state_d == S_BLANK || state_d == S_IDLE) blank_q <= 1'b1;
         else if (state_q == S_UNBLANK)               blank_q <= 1'b0;
         case (state_q)
            S_IDLE: if (enable) begin
               row_q   <= '0;
               plane_q <= '0;
            end
            S_LATCH: begin
               addr_q      <= row_q;
               lat_plane_q <= plane_q;
            end
            S_UNBLANK: if (last_plane) begin
               plane_q <= '0;
               row_q   <= row_q + ROW_BITS'(1);
            end else begin
               plane_q <= plane_q + PLANE_BITS'(1);
            end
            default: ;
         endcase
      end
   end

   led_on_timer #(.TICK_BITS(TICK_BITS)) u_on_timer (
      .clk    (clk),
      .resetn (resetn),
      .load   (timer_load),
      .value  (load_value),
      .zero   (timer_zero)
   );

   assign shift_row   = row_q;
   assign shift_plane = plane_q;
   assign led_addr    = addr_q;
   assign led_blank   = blank_q;
   assign busy        = (state_q != S_IDLE);
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_led_bcm_scheduler.sv
// Self-checking bench for led_bcm_scheduler: a 4-row/3-plane instance with a
// reference model of scan order and on-times, plus a 2-row/2-plane instance for frame wrap.
module tb_led_bcm_scheduler;
   import led_pkg::*;

   localparam int RB   = 2;
   localparam int PL   = 3;
   localparam int BASE = 4;
   localparam int ROWS = 1 << RB;

   logic          clk, resetn, enable, shift_done, shift_start;
   logic          led_latch, led_blank, frame_strobe, busy;
   logic [RB-1:0] shift_row, led_addr;
   logic [1:0]    shift_plane;
   state_t        fsm_state;
   logic          enable2, done2, start2, row2, plane2, addr2;
   logic          latch2, blank2, strobe2, busy2;
   state_t        state2;
`ifdef LED_SCHED_WATCHDOG_EN
   logic          shift_timeout, timeout2;
`endif

   led_bcm_scheduler #(.ROW_BITS(RB), .PLANES(PL), .BASE_TICKS(BASE), .TICK_BITS(16)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .shift_start(shift_start),
      .shift_row(shift_row), .shift_plane(shift_plane), .shift_done(shift_done),
      .led_addr(led_addr), .led_latch(led_latch), .led_blank(led_blank),
      .frame_strobe(frame_strobe), .busy(busy),
`ifdef LED_SCHED_WATCHDOG_EN
      .shift_timeout(shift_timeout),
`endif
      .fsm_state(fsm_state)
   );

   led_bcm_scheduler #(.ROW_BITS(1), .PLANES(2), .BASE_TICKS(BASE), .TICK_BITS(16)) dut_small (
      .clk(clk), .resetn(resetn), .enable(enable2), .shift_start(start2),
      .shift_row(row2), .shift_plane(plane2), .shift_done(done2),
      .led_addr(addr2), .led_latch(latch2), .led_blank(blank2),
      .frame_strobe(strobe2), .busy(busy2),
`ifdef LED_SCHED_WATCHDOG_EN
      .shift_timeout(timeout2),
`endif
      .fsm_state(state2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks, n_errors;
   int done_delay, cur_delay;
   bit rand_delay, resp_on, mon_on, mon2_on;

   // reference model state
   int exp_idx, last_row, last_plane, lat_row, lat_plane, addr_exp, latch_count;
   bit latch_prev, addr_pending, in_run;
   int run_len, hold_len;
   logic [15:0] exp_q[$];
   int runs_q[$], holds_q[$];
   int seq2_q[$], cyc2_q[$];
   int cyc2, strobe2_n, strobe2_cyc;

   typedef struct {
      int delay;
      int len[3];
      int hold[3];
   } vec_t;
   vec_t vecs[4];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int imax(int a, int b);
      return (a > b) ? a : b;
   endfunction

   task automatic set_vec(int i, int d, int l0, int l1, int l2, int h0, int h1, int h2);
      vecs[i].delay = d;
      vecs[i].len[0] = l0;  vecs[i].len[1] = l1;  vecs[i].len[2] = l2;
      vecs[i].hold[0] = h0; vecs[i].hold[1] = h1; vecs[i].hold[2] = h2;
   endtask

   task automatic init_model();
      exp_idx = 0; last_row = 0; last_plane = 0; lat_row = 0; lat_plane = 0;
      addr_exp = 0; latch_count = 0; latch_prev = 0; addr_pending = 0; in_run = 0;
      run_len = 0; hold_len = 0;
      exp_q.delete(); runs_q.delete(); holds_q.delete();
      seq2_q.delete(); cyc2_q.delete();
      cyc2 = 0; strobe2_n = 0; strobe2_cyc = -1;
   endtask

   // Shifter stand-in: answers each start with a done pulse `delay` cycles later.
   task automatic responder();
      int cnt;
      cnt = 0;
      shift_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         shift_done = 1'b0;
         if (!resetn) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) shift_done = 1'b1;
            end
            if (shift_start && resp_on) begin
               cnt = rand_delay ? int'($urandom_range(1, 25)) : done_delay;
               cur_delay = cnt;
            end
         end
      end
   endtask

   task automatic responder2();
      bit pend;
      pend = 0;
      done2 = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         done2 = 1'b0;
         if (!resetn) pend = 0;
         else begin
            if (pend) begin
               done2 = 1'b1;
               pend  = 0;
            end
            if (start2) pend = 1;
         end
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("frame_strobe", frame_strobe,
                  32'(latch_prev && lat_row == ROWS - 1 && lat_plane == PL - 1));
            latch_prev = led_latch;
            if (addr_pending) begin
               check("led_addr", led_addr, addr_exp);
               addr_pending = 0;
            end
            if (shift_start) begin
               last_row   = (exp_idx / PL) % ROWS;
               last_plane = exp_idx % PL;
               check("shift_row", shift_row, last_row);
               check("shift_plane", shift_plane, last_plane);
               exp_idx++;
            end
            if (led_latch) begin
               check("blank_at_latch", led_blank, 1);
               lat_row = last_row;
               lat_plane = last_plane;
               addr_exp = last_row;
               addr_pending = 1;
               latch_count++;
            end
            // Lit time = plane weight, stretched if the overlapped shift is slower.
            if (!led_blank) begin
               if (!in_run) begin
                  in_run = 1;
                  run_len = 0;
                  hold_len = 0;
                  exp_q.push_back(16'(imax(cur_delay + 2, BASE << lat_plane)));
               end
               run_len++;
               if (fsm_state == S_HOLD) hold_len++;
            end else if (in_run) begin
               in_run = 0;
               check("blank_low_len", run_len, exp_q.pop_front());
               runs_q.push_back(run_len);
               holds_q.push_back(hold_len);
            end
         end
      end
   endtask

   task automatic monitor2();
      forever begin
         @(negedge clk);
         if (mon2_on) begin
            cyc2++;
            if (start2) begin
               seq2_q.push_back(int'(row2) * 2 + int'(plane2));
               cyc2_q.push_back(cyc2);
            end
            if (strobe2) begin
               strobe2_n++;
               strobe2_cyc = cyc2;
            end
         end
      end
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_blank"}, led_blank, 1);
      check({tag, "_latch"}, led_latch, 0);
      check({tag, "_start"}, shift_start, 0);
      check({tag, "_strobe"}, frame_strobe, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_addr"}, led_addr, 0);
      check({tag, "_row"}, shift_row, 0);
      check({tag, "_plane"}, shift_plane, 0);
      check({tag, "_state"}, fsm_state, S_IDLE);
`ifdef LED_SCHED_WATCHDOG_EN
      check({tag, "_timeout"}, shift_timeout, 0);
`endif
   endtask

   task automatic do_reset();
      mon_on = 0;
      mon2_on = 0;
      enable = 0;
      enable2 = 0;
      resetn = 0;
      repeat (3) @(negedge clk);
      init_model();
      resetn = 1;
      @(negedge clk);
      mon_on = 1;
   endtask

   initial begin
      int lc, shift_cyc;
      bit saw_hold;
      int exp_small[5];

      n_checks = 0; n_errors = 0;
      resetn = 0; enable = 0; enable2 = 0;
      done_delay = 1; cur_delay = 1; rand_delay = 0; resp_on = 1;
      mon_on = 0; mon2_on = 0;
      init_model();
      // delay, blank-low length per plane 0..2, HOLD cycles per plane 0..2
      set_vec(0, 1,  4,  8, 16,  2, 6, 14);
      set_vec(1, 3,  5,  8, 16,  1, 4, 12);
      set_vec(2, 7,  9,  9, 16,  1, 1,  8);
      set_vec(3, 15, 17, 17, 17, 1, 1,  1);
      exp_small[0] = 0; exp_small[1] = 1; exp_small[2] = 2; exp_small[3] = 3; exp_small[4] = 0;
      fork
         responder();
         responder2();
         monitor();
         monitor2();
      join_none

      repeat (3) @(negedge clk);
      check_reset_values("por");
      resetn = 1;
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_blank", led_blank, 1);

      // first frame start: slow first shift, fast shifts after
      do_reset();
      done_delay = 3;
      enable = 1;
      for (int i = 0; i < 50 && !shift_start; i++) @(negedge clk);
      check("first_start_seen", shift_start, 1);
      check("first_start_row", shift_row, 0);
      check("first_start_plane", shift_plane, 0);
      done_delay = 1;
      for (int i = 0; i < 100 && runs_q.size() < 1; i++) @(negedge clk);
      check("first_run_seen", 32'(runs_q.size() >= 1), 1);
      if (runs_q.size() >= 1) check("first_on_time", runs_q[0], 4);

      for (int v = 0; v < 4; v++) begin
         do_reset();
         done_delay = vecs[v].delay;
         enable = 1;
         for (int i = 0; i < 600 && runs_q.size() < 3; i++) @(negedge clk);
         check($sformatf("vec%0d_runs", v), 32'(runs_q.size() >= 3), 1);
         if (runs_q.size() >= 3) begin
            for (int p = 0; p < 3; p++) begin
               check($sformatf("vec%0d_len_p%0d", v, p), runs_q[p], vecs[v].len[p]);
               check($sformatf("vec%0d_hold_p%0d", v, p), holds_q[p], vecs[v].hold[p]);
            end
         end
         enable = 0;
      end

      // randomized shifter latency over two full frames
      do_reset();
      rand_delay = 1;
      enable = 1;
      for (int i = 0; i < 4000 && exp_idx < 2 * ROWS * PL + 2; i++) @(negedge clk);
      check("rand_progress", 32'(exp_idx >= 2 * ROWS * PL + 2), 1);
      enable = 0;
      rand_delay = 0;
      for (int i = 0; i < 200 && fsm_state != S_IDLE; i++) @(negedge clk);
      check("rand_stops", fsm_state, S_IDLE);

      // enable dropped during a shift
      do_reset();
      done_delay = 5;
      enable = 1;
      for (int i = 0; i < 400 && latch_count < 2; i++) @(negedge clk);
      for (int i = 0; i < 100 && !shift_start; i++) @(negedge clk);
      check("drop_start_seen", shift_start, 1);
      enable = 0;
      lc = latch_count;
      saw_hold = 0;
      for (int i = 0; i < 400 && fsm_state != S_IDLE; i++) begin
         @(negedge clk);
         if (fsm_state == S_HOLD) saw_hold = 1;
      end
      check("drop_idle", fsm_state, S_IDLE);
      check("drop_shift_done", saw_hold, 1);
      check("drop_blank", led_blank, 1);
      check("drop_busy", busy, 0);
      repeat (10) @(negedge clk);
      check("drop_no_latch", latch_count, lc);
      check("drop_stays_idle", busy, 0);

      // asynchronous reset while holding a lit row
      do_reset();
      done_delay = 1;
      enable = 1;
      for (int i = 0; i < 600 && !(fsm_state == S_HOLD && led_blank == 1'b0 && led_addr != '0); i++)
         @(negedge clk);
      check("hold_reached", 32'(fsm_state == S_HOLD && led_addr != '0), 1);
      mon_on = 0;
      #2 resetn = 0;
      #1 check_reset_values("hold_rst");
      enable = 0;

      // small panel frame wrap
      do_reset();
      mon2_on = 1;
      enable2 = 1;
      for (int i = 0; i < 400 && seq2_q.size() < 5; i++) @(negedge clk);
      check("small_starts", 32'(seq2_q.size() >= 5), 1);
      if (seq2_q.size() >= 5) begin
         for (int k = 0; k < 5; k++) check($sformatf("small_seq%0d", k), seq2_q[k], exp_small[k]);
         check("small_strobe_cycle", strobe2_cyc, cyc2_q[4] - 1);
      end
      check("small_strobe_count", strobe2_n, 1);
      enable2 = 0;

`ifdef LED_SCHED_WATCHDOG_EN
      do_reset();
      resp_on = 0;
      enable = 1;
      shift_cyc = 0;
      for (int i = 0; i < 600 && !(fsm_state == S_IDLE && shift_cyc > 0); i++) begin
         @(negedge clk);
         if (fsm_state == S_SHIFT) shift_cyc++;
      end
      check("wd_shift_cycles", shift_cyc, 255);
      check("wd_timeout", shift_timeout, 1);
      check("wd_blank", led_blank, 1);
      enable = 0;
      resp_on = 1;
      repeat (5) @(negedge clk);
      check("wd_sticky", shift_timeout, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
